// File: rtl/wb_pipe.sv
// Write-back stage: retires ALU results or aligned/extended load data, waiting for late load data.
// Optional trace outputs (instruction, PC, raw load word, retire counter) are enabled by WB_PIPE_TRACE_EN.
module wb_pipe #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_vld,
  output logic              o_rdy,
  input  logic              i_mem_reg,
  input  logic [2:0]        i_funct3,
  input  logic [XLEN-1:0]   i_dmem_addr,
  input  logic              i_dmem_rvld,
  input  logic [XLEN-1:0]   i_dmem_rdata,
  input  logic [XLEN-1:0]   i_res,
  input  logic [REG_AW-1:0] i_rd_waddr,
  input  logic              i_rd_wen,
  input  logic [31:0]       i_inst,
  input  logic [XLEN-1:0]   i_pc,
  output logic              o_rd_wen,
  output logic [REG_AW-1:0] o_rd_waddr,
  output logic [XLEN-1:0]   o_rd_wdata,
  output logic              o_vld,
  output logic [31:0]       o_inst,
  output logic [XLEN-1:0]   o_pc,
  output logic [XLEN-1:0]   o_dmem_rdata,
  output logic [63:0]       o_retire_cnt
);

  localparam int LANE_W = $clog2(XLEN / 8);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t              state, state_nxt;
  logic                retire, capture, sel_load;
  logic [REG_AW-1:0]   sel_waddr, cap_waddr;
  logic                sel_wen, cap_wen, out_wen;
  logic [2:0]          sel_funct3, cap_funct3;
  logic [LANE_W-1:0]   sel_lane, cap_lane;
  logic [XLEN-1:0]     wdata_nxt;

  // Shift the addressed lane down (offset truncated to the access size), then extend.
  function automatic logic [XLEN-1:0] load_align(input logic [XLEN-1:0] raw,
                                                 input logic [2:0]      f3,
                                                 input logic [LANE_W-1:0] lane);
    logic [LANE_W-1:0] off;
    logic [XLEN-1:0]   sh;
    logic [XLEN-1:0]   res;
    off = '0;
    case (f3)
      3'b000, 3'b100: off = lane;
      3'b001, 3'b101: off = {lane[LANE_W-1:1], 1'b0};
      3'b010, 3'b110: if (XLEN == 64) off[LANE_W-1] = lane[LANE_W-1];
      default:        off = '0;
    endcase
    sh  = raw >> {off, 3'b000};
    res = raw;
    case (f3)
      3'b000: res = XLEN'($signed(sh[7:0]));
      3'b001: res = XLEN'($signed(sh[15:0]));
      3'b010: res = XLEN'($signed(sh[31:0]));
      3'b100: res = XLEN'(sh[7:0]);
      3'b101: res = XLEN'(sh[15:0]);
      3'b110: if (XLEN == 64) res = XLEN'(sh[31:0]);
      3'b011: if (XLEN == 64) res = sh;
      default: res = raw;
    endcase
    return res;
  endfunction

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_nxt  = state;
    retire     = 1'b0;
    capture    = 1'b0;
    sel_load   = 1'b0;
    sel_waddr  = i_rd_waddr;
    sel_wen    = i_rd_wen;
    sel_funct3 = i_funct3;
    sel_lane   = i_dmem_addr[LANE_W-1:0];
    case (state)
      IDLE: begin
        if (i_vld) begin
          if (i_mem_reg && !i_dmem_rvld) begin
            capture   = 1'b1;
            state_nxt = WAIT;
          end else begin
            retire   = 1'b1;
            sel_load = i_mem_reg;
          end
        end
      end
      WAIT: begin
        sel_waddr  = cap_waddr;
        sel_wen    = cap_wen;
        sel_funct3 = cap_funct3;
        sel_lane   = cap_lane;
        if (i_dmem_rvld) begin
          retire    = 1'b1;
          sel_load  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign wdata_nxt = sel_load ? load_align(i_dmem_rdata, sel_funct3, sel_lane) : i_res;
  assign o_rdy     = (state == IDLE);
  assign o_rd_wen  = o_vld & out_wen & (o_rd_waddr != '0);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      cap_waddr  <= '0;
      cap_wen    <= 1'b0;
      cap_funct3 <= '0;
      cap_lane   <= '0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        cap_waddr  <= i_rd_waddr;
        cap_wen    <= i_rd_wen;
        cap_funct3 <= i_funct3;
        cap_lane   <= i_dmem_addr[LANE_W-1:0];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_vld      <= 1'b0;
      out_wen    <= 1'b0;
      o_rd_waddr <= '0;
      o_rd_wdata <= '0;
    end else begin
      o_vld <= retire;
      if (retire) begin
        out_wen    <= sel_wen;
        o_rd_waddr <= sel_waddr;
        o_rd_wdata <= wdata_nxt;
      end
    end
  end

  logic unused_addr;
  assign unused_addr = ^{1'b0, i_dmem_addr[XLEN-1:LANE_W]};

`ifdef WB_PIPE_TRACE_EN
  logic [31:0]     cap_inst;
  logic [XLEN-1:0] cap_pc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cap_inst     <= '0;
      cap_pc       <= '0;
      o_inst       <= '0;
      o_pc         <= '0;
      o_dmem_rdata <= '0;
      o_retire_cnt <= '0;
    end else begin
      if (capture) begin
        cap_inst <= i_inst;
        cap_pc   <= i_pc;
      end
      if (retire) begin
        o_inst       <= (state == WAIT) ? cap_inst : i_inst;
        o_pc         <= (state == WAIT) ? cap_pc : i_pc;
        o_dmem_rdata <= sel_load ? i_dmem_rdata : '0;
        o_retire_cnt <= o_retire_cnt + 64'd1;
      end
    end
  end
`else
  logic unused_trace;
  assign unused_trace = ^{1'b0, i_inst, i_pc};
  assign o_inst       = '0;
  assign o_pc         = '0;
  assign o_dmem_rdata = '0;
  assign o_retire_cnt = '0;
`endif

endmodule

// File: tb/tb_wb_pipe.sv
// Scoreboard bench for wb_pipe: one XLEN=32 and one XLEN=64 instance share the same stimulus,
// each checked against a byte-level load model.
module tb_wb_pipe;

  typedef struct {
    logic [4:0]  waddr;
    logic        rd_wen;
    logic [63:0] wdata;
    logic [31:0] inst;
    logic [63:0] pc;
    logic [63:0] raw;
  } exp_t;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_vld = 1'b0, i_mem_reg = 1'b0, i_dmem_rvld = 1'b0, i_rd_wen = 1'b0;
  logic [2:0]  i_funct3 = '0;
  logic [63:0] i_dmem_addr = '0, i_dmem_rdata = '0, i_res = '0, i_pc = '0;
  logic [4:0]  i_rd_waddr = '0;
  logic [31:0] i_inst = '0;

  logic        rdy_a, wen_a, vld_a, rdy_b, wen_b, vld_b;
  logic [4:0]  wa_a, wa_b;
  logic [31:0] wd_a, pc_a, raw_a, inst_a, inst_b;
  logic [63:0] wd_b, pc_b, raw_b, cnt_a, cnt_b;

  int   total = 0;
  int   bad = 0;
  exp_t q[2][$];
  logic [63:0] last_wd[2];
  logic [4:0]  last_wa[2];
  longint      pulses[2];

  always #5 i_clk = ~i_clk;

  wb_pipe #(.XLEN(32), .REG_AW(5)) dut_a (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_vld(i_vld), .o_rdy(rdy_a),
    .i_mem_reg(i_mem_reg), .i_funct3(i_funct3), .i_dmem_addr(i_dmem_addr[31:0]),
    .i_dmem_rvld(i_dmem_rvld), .i_dmem_rdata(i_dmem_rdata[31:0]), .i_res(i_res[31:0]),
    .i_rd_waddr(i_rd_waddr), .i_rd_wen(i_rd_wen), .i_inst(i_inst), .i_pc(i_pc[31:0]),
    .o_rd_wen(wen_a), .o_rd_waddr(wa_a), .o_rd_wdata(wd_a), .o_vld(vld_a),
    .o_inst(inst_a), .o_pc(pc_a), .o_dmem_rdata(raw_a), .o_retire_cnt(cnt_a)
  );

  wb_pipe #(.XLEN(64), .REG_AW(5)) dut_b (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_vld(i_vld), .o_rdy(rdy_b),
    .i_mem_reg(i_mem_reg), .i_funct3(i_funct3), .i_dmem_addr(i_dmem_addr),
    .i_dmem_rvld(i_dmem_rvld), .i_dmem_rdata(i_dmem_rdata), .i_res(i_res),
    .i_rd_waddr(i_rd_waddr), .i_rd_wen(i_rd_wen), .i_inst(i_inst), .i_pc(i_pc),
    .o_rd_wen(wen_b), .o_rd_waddr(wa_b), .o_rd_wdata(wd_b), .o_vld(vld_b),
    .o_inst(inst_b), .o_pc(pc_b), .o_dmem_rdata(raw_b), .o_retire_cnt(cnt_b)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference load: pick the access size, round the byte offset down to it, mask and extend.
  function automatic logic [63:0] model_load(input logic [63:0] raw, input logic [2:0] f3,
                                             input logic [63:0] addr, input int xlen);
    int          nbytes;
    bit          sgn;
    int          off;
    logic [63:0] xmask, v, m;
    xmask = (xlen == 64) ? '1 : 64'hFFFF_FFFF;
    raw   = raw & xmask;
    sgn   = 1'b0;
    case (f3)
      3'd0: begin nbytes = 1; sgn = 1'b1; end
      3'd1: begin nbytes = 2; sgn = 1'b1; end
      3'd2: begin nbytes = 4; sgn = 1'b1; end
      3'd4: nbytes = 1;
      3'd5: nbytes = 2;
      3'd6: if (xlen == 64) nbytes = 4; else return raw;
      3'd3: if (xlen == 64) nbytes = 8; else return raw;
      default: return raw;
    endcase
    off = int'(addr % 64'(xlen / 8));
    off = off - (off % nbytes);
    v   = raw >> (8 * off);
    if (nbytes < 8) begin
      m = (64'd1 << (8 * nbytes)) - 64'd1;
      v = v & m;
      if (sgn && v[8*nbytes-1]) v = v | ~m;
    end
    return v & xmask;
  endfunction

  task automatic mon(input int idx, input logic v, input logic we, input logic [4:0] wa,
                     input logic [63:0] wd, input logic [31:0] inst, input logic [63:0] pc,
                     input logic [63:0] raw, input logic [63:0] cnt);
    exp_t e;
    if (!i_rst_n) begin
      check($sformatf("rst_vld%0d", idx), 64'(v), 64'd0);
      last_wd[idx] = '0;
      last_wa[idx] = '0;
      pulses[idx]  = 0;
    end else if (v) begin
      if (q[idx].size() == 0) begin
        check($sformatf("unexpected_vld%0d", idx), 64'(v), 64'd0);
      end else begin
        e = q[idx].pop_front();
        pulses[idx]++;
        check($sformatf("waddr%0d", idx), 64'(wa), 64'(e.waddr));
        check($sformatf("rd_wen%0d", idx), 64'(we), 64'(e.rd_wen));
        check($sformatf("wdata%0d", idx), wd, e.wdata);
`ifdef WB_PIPE_TRACE_EN
        check($sformatf("inst%0d", idx), 64'(inst), 64'(e.inst));
        check($sformatf("pc%0d", idx), pc, e.pc);
        check($sformatf("raw%0d", idx), raw, e.raw);
        check($sformatf("retire_cnt%0d", idx), cnt, 64'(pulses[idx]));
`else
        check($sformatf("trace_zero%0d", idx), 64'(inst) | pc | raw | cnt, 64'd0);
`endif
      end
      last_wd[idx] = wd;
      last_wa[idx] = wa;
    end else begin
      check($sformatf("hold_wdata%0d", idx), wd, last_wd[idx]);
      check($sformatf("hold_waddr%0d", idx), 64'(wa), 64'(last_wa[idx]));
      check($sformatf("idle_rd_wen%0d", idx), 64'(we), 64'd0);
    end
  endtask

  initial begin
    forever begin
      @(posedge i_clk);
      #1;
      mon(0, vld_a, wen_a, wa_a, {32'b0, wd_a}, inst_a, {32'b0, pc_a}, {32'b0, raw_a}, cnt_a);
      mon(1, vld_b, wen_b, wa_b, wd_b, inst_b, pc_b, raw_b, cnt_b);
    end
  end

  // Drives one instruction (releasing reset if held) and its load data after dly WAIT cycles.
  task automatic issue(input bit is_ld, input logic [2:0] f3, input logic [4:0] rd,
                       input bit wen, input logic [63:0] addr, input logic [63:0] rdata,
                       input logic [63:0] res, input int dly);
    exp_t e;
    logic [63:0] xm;
    @(negedge i_clk);
    i_rst_n      = 1'b1;
    i_vld        = 1'b1;
    i_mem_reg    = is_ld;
    i_funct3     = f3;
    i_rd_waddr   = rd;
    i_rd_wen     = wen;
    i_dmem_addr  = addr;
    i_res        = res;
    i_inst       = $urandom;
    i_pc         = {$urandom, $urandom};
    i_dmem_rvld  = is_ld ? (dly == 0) : 1'($urandom_range(0, 1));
    i_dmem_rdata = (is_ld && dly > 0) ? {$urandom, $urandom} : rdata;
    check("rdy_idle_a", 64'(rdy_a), 64'd1);
    check("rdy_idle_b", 64'(rdy_b), 64'd1);
    for (int k = 0; k < 2; k++) begin
      xm       = (k == 1) ? '1 : 64'hFFFF_FFFF;
      e.waddr  = rd;
      e.rd_wen = wen && (rd != 5'd0);
      e.wdata  = is_ld ? model_load(rdata, f3, addr, (k == 1) ? 64 : 32) : (res & xm);
      e.inst   = i_inst;
      e.pc     = i_pc & xm;
      e.raw    = is_ld ? (rdata & xm) : 64'd0;
      q[k].push_back(e);
    end
    if (is_ld) begin
      for (int k = 0; k < dly; k++) begin
        @(negedge i_clk);
        check("rdy_wait_a", 64'(rdy_a), 64'd0);
        check("rdy_wait_b", 64'(rdy_b), 64'd0);
        i_vld        = 1'($urandom_range(0, 1));
        i_mem_reg    = 1'($urandom_range(0, 1));
        i_funct3     = 3'($urandom);
        i_rd_waddr   = 5'($urandom);
        i_rd_wen     = 1'($urandom);
        i_dmem_addr  = {$urandom, $urandom};
        i_res        = {$urandom, $urandom};
        i_inst       = $urandom;
        i_dmem_rvld  = (k == dly - 1);
        i_dmem_rdata = (k == dly - 1) ? rdata : {$urandom, $urandom};
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge i_clk);
      i_vld        = 1'b0;
      i_dmem_rvld  = 1'($urandom_range(0, 1));
      i_dmem_rdata = {$urandom, $urandom};
    end
  endtask

  task automatic drain();
    int n;
    @(negedge i_clk);
    i_vld       = 1'b0;
    i_dmem_rvld = 1'b0;
    n = 0;
    while ((q[0].size() != 0 || q[1].size() != 0) && n < 50) begin
      @(negedge i_clk);
      n++;
    end
    check("drain_a", 64'(q[0].size()), 64'd0);
    check("drain_b", 64'(q[1].size()), 64'd0);
  endtask

  initial begin
    logic [2:0] f3;
    bit         ld;
    repeat (3) @(negedge i_clk);
    check("rst_rdy_a", 64'(rdy_a), 64'd1);
    check("rst_rdy_b", 64'(rdy_b), 64'd1);
    check("rst_out_a", {31'b0, vld_a, wd_a} | cnt_a, 64'd0);
    check("rst_out_b", 64'(vld_b) | wd_b | cnt_b, 64'd0);

    // Directed cases; the first one also releases reset on its accept edge.
    issue(0, 3'b000, 5'd5, 1, 64'h0, 64'h0, 64'h1234, 0);
    issue(1, 3'b000, 5'd7, 1, 64'h1003, 64'h80FF_FFFF, 64'h0, 0);
    issue(1, 3'b100, 5'd7, 1, 64'h1003, 64'h80FF_FFFF, 64'h0, 0);
    issue(1, 3'b001, 5'd9, 1, 64'h2002, 64'h8001_0000, 64'h0, 3);
    issue(0, 3'b000, 5'd0, 1, 64'h0, 64'h0, 64'hDEAD, 0);
    issue(1, 3'b110, 5'd3, 1, 64'h4, 64'hFFFF_FFFF_0000_0000, 64'h0, 1);
    issue(1, 3'b011, 5'd4, 1, 64'h5, 64'h8877_6655_4433_2211, 64'h0, 2);
    idle(3);

    for (int n = 0; n < 300; n++) begin
      ld = ($urandom_range(0, 2) != 0);
      f3 = 3'($urandom);
      issue(ld, f3, ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), 1'($urandom),
            {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
            $urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 2));
    end
    drain();

    // Reset while a load waits: the held instruction must vanish and late data be ignored.
    @(negedge i_clk);
    i_vld = 1'b1; i_mem_reg = 1'b1; i_funct3 = 3'b010; i_rd_waddr = 5'd6; i_rd_wen = 1'b1;
    i_dmem_rvld = 1'b0;
    @(negedge i_clk);
    i_vld = 1'b0;
    check("wait_rdy_a", 64'(rdy_a), 64'd0);
    check("wait_rdy_b", 64'(rdy_b), 64'd0);
    #2 i_rst_n = 1'b0;
    #1;
    check("async_rst_rdy_a", 64'(rdy_a), 64'd1);
    check("async_rst_rdy_b", 64'(rdy_b), 64'd1);
    @(negedge i_clk);
    i_rst_n      = 1'b1;
    i_dmem_rvld  = 1'b1;
    i_dmem_rdata = {$urandom, $urandom};
    @(negedge i_clk);
    i_dmem_rvld = 1'b0;
    repeat (2) @(negedge i_clk);
    check("post_rst_rdy_a", 64'(rdy_a), 64'd1);
    check("post_rst_rdy_b", 64'(rdy_b), 64'd1);
    check("post_rst_cnt_a", cnt_a, 64'd0);
    check("post_rst_cnt_b", cnt_b, 64'd0);

    // Reset again; accept on the very first edge after release.
    i_rst_n = 1'b0;
    issue(0, 3'b000, 5'd12, 1, 64'h0, 64'h0, 64'h5A5A_0F0F, 0);
    issue(1, 3'b101, 5'd13, 1, 64'h6, 64'hBEEF_0000_CAFE_1234, 64'h0, 0);
    drain();
    repeat (2) @(negedge i_clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_pipe.md
WB_PIPE -- requirements
Module: wb_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 SHALL have parameter REG_AW, default 5, register-file address width.
REQ-003 SHALL have ports: i_clk  in  1  clock; i_rst_n  in  1  reset.
REQ-004 SHALL use one clock, i_clk; reset i_rst_n is asynchronous and active-low.
REQ-005 SHALL have i_vld  in  1  upstream instruction valid; o_rdy  out  1  stage can accept.
REQ-006 SHALL have i_mem_reg  in  1  result comes from load data; i_funct3  in  3  load size/sign.
REQ-007 SHALL have i_dmem_addr  in  XLEN  load byte address; i_dmem_rvld  in  1  load data valid; i_dmem_rdata  in  XLEN  raw load word.
REQ-008 SHALL have i_res  in  XLEN  ALU result; i_rd_waddr  in  REG_AW; i_rd_wen  in  1.
REQ-009 SHALL have i_inst  in  32; i_pc  in  XLEN  (trace only).
REQ-010 SHALL have o_rd_wen  out  1; o_rd_waddr  out  REG_AW; o_rd_wdata  out  XLEN; o_vld  out  1  retire pulse.
REQ-011 SHALL have o_inst  out  32; o_pc  out  XLEN; o_dmem_rdata  out  XLEN  raw word; o_retire_cnt  out  64.

Function
REQ-012 SHALL implement FSM states IDLE and WAIT; o_rdy = 1 in IDLE, 0 in WAIT.
REQ-013 IDLE, accept (i_vld & o_rdy) with i_mem_reg=0 or i_dmem_rvld=1: SHALL register the result; o_vld=1 on the next cycle; stay IDLE.
REQ-014 IDLE, accept with i_mem_reg=1 and i_dmem_rvld=0: SHALL capture rd_waddr, rd_wen, funct3, addr low bits, inst and pc; go to WAIT.
REQ-015 WAIT: SHALL ignore i_vld; on i_dmem_rvld=1, register the aligned load result; o_vld=1 on the next cycle; return to IDLE.
REQ-016 o_vld SHALL be a one-cycle pulse per accepted instruction, including when rd_wen=0.
REQ-017 o_rd_wen SHALL equal o_vld & captured rd_wen & (rd_waddr != 0); writes to x0 are suppressed.
REQ-018 Load lane offset SHALL be addr[log2(XLEN/8)-1:0], truncated to the access size (LH ignores addr[0]; LW ignores addr[1:0] below word).
REQ-019 funct3 000/001/010 SHALL sign-extend byte/half/word; 100/101 SHALL zero-extend; 110 (LWU) and 011 (LD) apply only when XLEN=64.
REQ-020 Any other funct3, or an XLEN=64-only code when XLEN=32, SHALL return the raw word unmodified.
REQ-021 i_dmem_rvld in IDLE with no load accepted SHALL be ignored.
REQ-022 o_dmem_rdata SHALL carry the raw word used, aligned with o_vld; it is 0 for non-loads.
REQ-023 Output fields SHALL hold their values between pulses; only o_vld and o_rd_wen deassert.

Reset
REQ-024 On i_rst_n=0 the FSM SHALL go to IDLE; all outputs and o_retire_cnt SHALL be 0.
REQ-025 Reset during WAIT SHALL discard the held instruction; no retire pulse occurs.
REQ-026 The first accept SHALL be possible on the first rising edge after i_rst_n rises.

Configuration
REQ-027 Macro WB_PIPE_TRACE_EN defined: o_inst, o_pc, o_dmem_rdata SHALL be registered alongside o_vld, and o_retire_cnt SHALL increment by 1 per o_vld pulse, wrapping at 2^64.
REQ-028 Macro undefined: o_inst, o_pc, o_dmem_rdata and o_retire_cnt SHALL be constant 0, with no trace registers present.

Verification
REQ-029 ALU op: i_res=0x1234, rd=5, wen=1 -> next cycle o_vld=1, o_rd_wen=1, o_rd_wdata=0x1234.
REQ-030 LB, XLEN=32, addr=0x...3, rdata=0x80FF_FFFF, same-cycle rvld -> o_rd_wdata=0xFFFF_FF80; repeat as LBU -> 0x0000_0080.
REQ-031 LH, addr[1]=1, rdata=0x8001_0000, rvld delayed 3 cycles -> o_rdy=0 for 3 cycles, then o_rd_wdata=0xFFFF_8001, one o_vld.
REQ-032 rd=0, wen=1, ALU op -> o_vld=1, o_rd_wen=0.
REQ-033 Load in WAIT, i_rst_n pulsed low, then rvld -> no o_vld; o_retire_cnt=0; o_rdy=1.
REQ-034 XLEN=64, LWU, addr[2]=1, rdata=0xFFFF_FFFF_0000_0000 -> o_rd_wdata=0x0000_0000_FFFF_FFFF; with WB_PIPE_TRACE_EN, o_retire_cnt increments by 1.
